output_argmax: RTL and testbench



---
 rtl/argmax_pkg.sv | 16 +
 rtl/argmax_cmp_update.sv | 41 ++++
 rtl/output_argmax.sv | 122 ++++++++++++
 tb/tb_output_argmax.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// rtl/argmax_pkg.sv - shared constants and state encoding for output_argmax
package argmax_pkg;

  localparam int N_CLASSES_DEF = 10;
  localparam int DW_DEF        = 8;
  localparam int IDX_W_DEF     = 4;

  localparam logic signed [7:0] MIN_SCORE = -8'sd128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/argmax_cmp_update.sv
// rtl/argmax_cmp_update.sv - one-step running max update (second-best tracked under ARGMAX_MARGIN_EN)
module argmax_cmp_update
  import argmax_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [DW-1:0]    second_val,
  output logic signed [DW-1:0]    second_next,
`endif
  input  logic signed [DW-1:0]    cand,
  input  logic        [IDX_W-1:0] cnt,
  input  logic signed [DW-1:0]    best_val,
  input  logic        [IDX_W-1:0] best_idx,
  output logic signed [DW-1:0]    best_val_next,
  output logic        [IDX_W-1:0] best_idx_next
);

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    best_val_next = best_val;
    best_idx_next = best_idx;
`ifdef ARGMAX_MARGIN_EN
    second_next   = second_val;
`endif
    if (cand > best_val) begin
      best_val_next = cand;
      best_idx_next = cnt;
`ifdef ARGMAX_MARGIN_EN
      second_next   = best_val;
`endif
    end
`ifdef ARGMAX_MARGIN_EN
    else if (cand > second_val) begin
      second_next = cand;
    end
`endif
  end

endmodule

// File: rtl/output_argmax.sv
// rtl/output_argmax.sv - captures class scores, scans for the argmax, holds result until ack (margin output under ARGMAX_MARGIN_EN)
module output_argmax
  import argmax_pkg::*;
#(
  parameter int N_CLASSES = N_CLASSES_DEF,
  parameter int DW        = DW_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      layer_ready,
  input  logic [0:N_CLASSES*DW-1]   layer_data,
  output logic                      received,
  output logic                      done,
  input  logic                      ack,
`ifdef ARGMAX_MARGIN_EN
  output logic [DW:0]               margin,
`endif
  output logic [IDX_W-1:0]          class_idx,
  output logic signed [DW-1:0]      max_val
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N_CLASSES - 1);

  state_t                   state_q, state_d;
  logic [0:N_CLASSES*DW-1]  score_buf;
  logic [IDX_W-1:0]         cnt;
  logic signed [DW-1:0]     best_val, best_val_next;
  logic [IDX_W-1:0]         best_idx, best_idx_next;
  logic signed [DW-1:0]     cand;
  logic                     last_cnt;

  assign cand     = score_buf[DW*int'(cnt) +: DW];
  assign last_cnt = (cnt == LAST_CNT);

`ifdef ARGMAX_MARGIN_EN
  localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
  logic signed [DW-1:0] second_val, second_next;
  logic        [DW:0]   margin_next;

  // best >= second always, so the sign-extended difference fits unsigned in DW+1 bits.
  assign margin_next = {best_val_next[DW-1], best_val_next} - {second_next[DW-1], second_next};
`endif

  argmax_cmp_update #(.DW(DW), .IDX_W(IDX_W)) u_cmp (
`ifdef ARGMAX_MARGIN_EN
    .second_val    (second_val),
    .second_next   (second_next),
`endif
    .cand          (cand),
    .cnt           (cnt),
    .best_val      (best_val),
    .best_idx      (best_idx),
    .best_val_next (best_val_next),
    .best_idx_next (best_idx_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (layer_ready) state_d = SCAN;
      SCAN:    if (last_cnt)    state_d = DONE;
      DONE:    if (ack)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_buf  <= '0;
      cnt        <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      received   <= 1'b0;
      done       <= 1'b0;
      class_idx  <= '0;
      max_val    <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_val <= '0;
      margin     <= '0;
`endif
    end else begin
      received <= 1'b0;
      case (state_q)
        IDLE: if (layer_ready) begin
          score_buf  <= layer_data;
          best_val   <= layer_data[0 +: DW];
          best_idx   <= '0;
          cnt        <= IDX_W'(1);
          received   <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
          second_val <= MIN_VAL;
`endif
        end
        SCAN: begin
          best_val   <= best_val_next;
          best_idx   <= best_idx_next;
          cnt        <= cnt + 1'b1;
`ifdef ARGMAX_MARGIN_EN
          second_val <= second_next;
`endif
          if (last_cnt) begin
            class_idx <= best_idx_next;
            max_val   <= best_val_next;
            done      <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
            margin    <= margin_next;
`endif
          end
        end
        DONE: if (ack) done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
// tb/tb_output_argmax.sv - table-driven self-checking bench for output_argmax (margin checked under ARGMAX_MARGIN_EN)
module tb_output_argmax;

  logic        clk = 1'b0;
  logic        rst;
  logic        layer_ready;
  logic [0:79] layer_data;
  logic        received;
  logic        done;
  logic        ack;
  logic [3:0]  class_idx;
  logic signed [7:0] max_val;
`ifdef ARGMAX_MARGIN_EN
  logic [8:0]  margin;
`endif

  int checks = 0;
  int errors = 0;

  output_argmax dut (
    .clk         (clk),
    .rst         (rst),
    .layer_ready (layer_ready),
    .layer_data  (layer_data),
    .received    (received),
    .done        (done),
    .ack         (ack),
`ifdef ARGMAX_MARGIN_EN
    .margin      (margin),
`endif
    .class_idx   (class_idx),
    .max_val     (max_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:79] data;
    int          idx;
    int          val;
    int          mrg;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [0:79] pack10(input int s[10]);
    logic [0:79] r;
    logic [31:0] w;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      w = s[i];
      r[8*i +: 8] = w[7:0];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic capture(input logic [0:79] d);
    @(negedge clk);
    layer_data  = d;
    layer_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("received_on_capture", int'(received), 1);
    layer_ready = 1'b0;
  endtask

  // Counts edges until done, scrambling layer_data every cycle to prove the capture is isolated.
  task automatic wait_done(output int lat, output int rcv);
    lat = 0;
    rcv = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (received) rcv++;
      layer_data = {16'($urandom), 32'($urandom), 32'($urandom)};
    end
    if (!done) lat = -1;
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    chk("done_cleared_by_ack", int'(done), 0);
    ack = 1'b0;
  endtask

  task automatic check_result(input string nm, input int e_idx, input int e_val, input int e_mrg);
    chk({nm, "_idx"}, int'(class_idx), e_idx);
    chk({nm, "_val"}, int'(max_val) & 255, e_val & 255);
`ifdef ARGMAX_MARGIN_EN
    chk({nm, "_margin"}, int'(margin), e_mrg);
`endif
  endtask

  initial begin
    int lat, rcv, bad;

    vecs[0] = '{pack10('{3, -5, 17, 0, 9, 17, -128, 2, 1, 16}), 2, 17, 0};
    vecs[1] = '{pack10('{-100, -100, -100, -100, -100, -100, -100, -100, -100, -1}), 9, -1, 99};
    vecs[2] = '{pack10('{0, 0, 0, 0, 0, 127, 0, 0, 0, 0}), 5, 127, 127};
    vecs[3] = '{pack10('{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128}), 0, -128, 0};
    vecs[4] = '{pack10('{7, 7, 7, 7, 7, 7, 7, 7, 7, 7}), 0, 7, 0};
    vecs[5] = '{pack10('{-128, -3, 5, 100, -1, 99, 2, 0, 127, 126}), 8, 127, 1};
    vecs[6] = '{pack10('{50, 49, -1, -1, -1, -1, -1, -1, -1, -1}), 0, 50, 1};

    rst = 1'b1;
    layer_ready = 1'b0;
    layer_data = '0;
    ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    bad = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (received || done || class_idx != 0 || max_val != 0) bad++;
    end
    chk("idle_after_reset", bad, 0);
`ifdef ARGMAX_MARGIN_EN
    chk("idle_margin", int'(margin), 0);
`endif

    for (int v = 0; v < 7; v++) begin
      capture(vecs[v].data);
      wait_done(lat, rcv);
      chk($sformatf("vec%0d_latency", v), lat, 9);
      chk($sformatf("vec%0d_received_width", v), rcv, 0);
      check_result($sformatf("vec%0d", v), vecs[v].idx, vecs[v].val, vecs[v].mrg);
      do_ack();
    end

    // Hold in DONE without ack while layer_ready toggles.
    capture(vecs[0].data);
    wait_done(lat, rcv);
    chk("hold_latency", lat, 9);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      layer_ready = i[0];
      @(posedge clk);
      #1;
      if (!done || received || class_idx != 4'd2 || max_val != 8'sd17) bad++;
    end
    chk("hold_stable", bad, 0);

    @(negedge clk);
    ack = 1'b1;
    layer_ready = 1'b1;
    layer_data = vecs[2].data;
    @(posedge clk);
    #1;
    chk("ack_and_ready_done", int'(done), 0);
    chk("ack_and_ready_no_capture", int'(received), 0);
    @(negedge clk);
    ack = 1'b0;
    @(posedge clk);
    #1;
    chk("capture_after_ack", int'(received), 1);
    layer_ready = 1'b0;
    wait_done(lat, rcv);
    chk("post_ack_latency", lat, 9);
    check_result("post_ack", 5, 127, 127);
    do_ack();

    // Reset on the 4th SCAN edge aborts the scan.
    capture(vecs[1].data);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_done", int'(done), 0);
    chk("abort_received", int'(received), 0);
    check_result("abort", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done || received) bad++;
    end
    chk("abort_quiet", bad, 0);

    capture(vecs[1].data);
    wait_done(lat, rcv);
    chk("rerun_latency", lat, 9);
    check_result("rerun", 9, -1, 99);
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
